// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA frame-buffer read engine:
//   - default 640x480@60 timing constants and the derived line/frame totals
//   - frame-buffer depth and address width
//   - 12-bit pixel packing {R[11:8], G[7:4], B[3:0]}
//   - pipeline flag bundle carried alongside each pixel
//   - colour-bar palette used by the optional test pattern
//     (VGA_TEST_PATTERN_EN)
// ---------------------------------------------------------------------------
package vga_pkg;

    localparam int   DEF_H_ACTIVE = 640;
    localparam int   DEF_H_FP     = 16;
    localparam int   DEF_H_SYNC   = 96;
    localparam int   DEF_H_BP     = 48;
    localparam int   DEF_V_ACTIVE = 480;
    localparam int   DEF_V_FP     = 10;
    localparam int   DEF_V_SYNC   = 2;
    localparam int   DEF_V_BP     = 33;
    localparam int   DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int   DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam logic DEF_SYNC_POL = 1'b0;

    localparam int   FB_DEPTH     = DEF_H_ACTIVE * DEF_V_ACTIVE;
    localparam int   DEF_ADDR_W   = 19;

    localparam int   BAR_WIDTH    = 80;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } pixel_t;

    // Flags are booleans (1 = inside the window); sync polarity is applied
    // only at the output pins.
    typedef struct packed {
        logic active;
        logic hsync;
        logic vsync;
        logic frame_start;
    } vga_flags_t;

    // Eight vertical bars, left to right.
    function automatic pixel_t bar_color(input logic [2:0] idx);
        pixel_t c;
        case (idx)
            3'd0:    c = pixel_t'(12'hFFF);  // white
            3'd1:    c = pixel_t'(12'hFF0);  // yellow
            3'd2:    c = pixel_t'(12'h0FF);  // cyan
            3'd3:    c = pixel_t'(12'h0F0);  // green
            3'd4:    c = pixel_t'(12'hF0F);  // magenta
            3'd5:    c = pixel_t'(12'hF00);  // red
            3'd6:    c = pixel_t'(12'h00F);  // blue
            default: c = pixel_t'(12'h000);  // black
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
// Horizontal/vertical raster counters and the raw (stage 0) timing flags.
// h_cnt runs 0..H_TOTAL-1; v_cnt steps on every h_cnt wrap and runs
// 0..V_TOTAL-1.
// Ports:
//   clk          in   pixel clock
//   reset        in   synchronous, active-high
//   o_h_cnt      out  current h_cnt (only with VGA_TEST_PATTERN_EN)
//   o_flags      out  active / hsync / vsync / frame_start for this count
//   o_frame_end  out  counters sit on the last position of the frame
// ---------------------------------------------------------------------------
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic       clk,
    input  logic       reset,
`ifdef VGA_TEST_PATTERN_EN
    output logic [9:0] o_h_cnt,
`endif
    output vga_flags_t o_flags,
    output logic       o_frame_end
);

    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;

    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    assign o_h_cnt = r_h_cnt;
`endif

    assign o_flags.active      = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
    assign o_flags.hsync       = (r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST);
    assign o_flags.vsync       = (r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST);
    assign o_flags.frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);
    assign o_frame_end         = (r_h_cnt == H_LAST) && (r_v_cnt == V_LAST);

endmodule

// File: rtl/vga_frame_reader.sv
// ---------------------------------------------------------------------------
// vga_frame_reader
// Read-side engine for the 640x480x12 frame buffer. Generates VGA timing,
// issues one buffer read per active pixel and drives the RGB/sync pins
// through a 3-stage pipeline (counters -> read request -> buffer data ->
// pins), so RGB, syncs and frame_start all trail the counters by 3 cycles.
// Optional feature: VGA_TEST_PATTERN_EN adds test_sel, which replaces the
// buffer data with 8 colour bars and suppresses buffer reads.
// Ports:
//   clk          in   25 MHz pixel clock (shared with the buffer read port)
//   reset        in   synchronous, active-high
//   test_sel     in   colour-bar select (only with VGA_TEST_PATTERN_EN)
//   rd_en        out  buffer read enable
//   rd_addr      out  buffer read address, holds while rd_en = 0
//   rd_data      in   {R,G,B} pixel, valid one cycle after rd_en
//   vga_r/g/b    out  4-bit colour, 0 during blanking
//   vga_hsync    out  horizontal sync, asserted level SYNC_POL
//   vga_vsync    out  vertical sync, asserted level SYNC_POL
//   frame_start  out  one-cycle pulse with pixel (0,0) on the pins
// ---------------------------------------------------------------------------
module vga_frame_reader
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter int   ADDR_W   = DEF_ADDR_W,
    parameter logic SYNC_POL = DEF_SYNC_POL
) (
    input  logic              clk,
    input  logic              reset,
`ifdef VGA_TEST_PATTERN_EN
    input  logic              test_sel,
`endif
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [11:0]       rd_data,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              frame_start
);

    vga_flags_t        w_flags;
    logic              w_frame_end;
    logic              w_rd_req;
    pixel_t            w_pixel;
    logic [ADDR_W-1:0] r_pix_cnt;
    vga_flags_t        r_s1_flags;
    vga_flags_t        r_s2_flags;

`ifdef VGA_TEST_PATTERN_EN
    logic [9:0]        w_h_cnt;
    logic [9:0]        r_s1_h_cnt;
    logic [9:0]        r_s2_h_cnt;
`endif

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk         (clk),
        .reset       (reset),
`ifdef VGA_TEST_PATTERN_EN
        .o_h_cnt     (w_h_cnt),
`endif
        .o_flags     (w_flags),
        .o_frame_end (w_frame_end)
    );

`ifdef VGA_TEST_PATTERN_EN
    assign w_rd_req = w_flags.active & ~test_sel;
`else
    assign w_rd_req = w_flags.active;
`endif

    // Pixel counter holds the address of the pixel the counters point at.
    // It parks at FB_DEPTH through vertical blanking and is cleared on the
    // last raster position, so it never relies on overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pix_cnt <= '0;
        end else if (w_frame_end) begin
            r_pix_cnt <= '0;
        end else if (w_flags.active) begin
            r_pix_cnt <= r_pix_cnt + 1'b1;
        end
    end

    // S1 issues the read; S2 is the cycle the buffer answers in.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_en      <= 1'b0;
            rd_addr    <= '0;
            r_s1_flags <= '0;
            r_s2_flags <= '0;
        end else begin
            rd_en      <= w_rd_req;
            if (w_rd_req) begin
                rd_addr <= r_pix_cnt;
            end
            r_s1_flags <= w_flags;
            r_s2_flags <= r_s1_flags;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_h_cnt <= '0;
            r_s2_h_cnt <= '0;
        end else begin
            r_s1_h_cnt <= w_h_cnt;
            r_s2_h_cnt <= r_s1_h_cnt;
        end
    end
`endif

    // NOTE: w_pixel receives its default before any conditional override,
    // so this block can never infer a latch.
    always_comb begin
        w_pixel = pixel_t'(rd_data);
`ifdef VGA_TEST_PATTERN_EN
        if (test_sel) begin
            w_pixel = bar_color(3'(r_s2_h_cnt / 10'(BAR_WIDTH)));
        end
`endif
    end

    // S3: pins. Blanking forces black regardless of what the buffer returns.
    always_ff @(posedge clk) begin
        if (reset) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hsync   <= ~SYNC_POL;
            vga_vsync   <= ~SYNC_POL;
            frame_start <= 1'b0;
        end else begin
            vga_r       <= r_s2_flags.active ? w_pixel.r : 4'h0;
            vga_g       <= r_s2_flags.active ? w_pixel.g : 4'h0;
            vga_b       <= r_s2_flags.active ? w_pixel.b : 4'h0;
            vga_hsync   <= r_s2_flags.hsync ? SYNC_POL : ~SYNC_POL;
            vga_vsync   <= r_s2_flags.vsync ? SYNC_POL : ~SYNC_POL;
            frame_start <= r_s2_flags.frame_start;
        end
    end

endmodule

// File: tb/tb_vga_frame_reader.sv
`timescale 1ns/1ps
module tb_vga_frame_reader;

    localparam int AW = 19;

    // Reduced raster for frame-level checks (frame = 56 * 17 = 952 cycles).
    localparam int S_HA = 40, S_HF = 4, S_HS = 6, S_HB = 6;
    localparam int S_VA = 10, S_VF = 2, S_VS = 3, S_VB = 2;
    localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
    localparam int S_FT = S_HT * (S_VA + S_VF + S_VS + S_VB);

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb;
        bit pol;
    } tim_t;

    typedef struct packed {
        logic          rd_en;
        logic [AW-1:0] rd_addr;
        logic [11:0]   rgb;
        logic          hs;
        logic          vs;
        logic          fs;
    } pins_t;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic        reset    = 1'b1;
    logic        test_sel = 1'b0;
    logic [11:0] key      = 12'h000;
    int          k        = 0;
    int          n_tests  = 0;
    int          n_fail   = 0;
    tim_t        td, ts;

    logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                              12'hF0F, 12'hF00, 12'h00F, 12'h000};

    // Default-timing DUT
    logic          d_rd_en, d_hs, d_vs, d_fs;
    logic [AW-1:0] d_rd_addr;
    logic [11:0]   d_rd_data;
    logic [3:0]    d_r, d_g, d_b;
    // Reduced-timing DUT, active-high syncs
    logic          s_rd_en, s_hs, s_vs, s_fs;
    logic [AW-1:0] s_rd_addr;
    logic [11:0]   s_rd_data;
    logic [3:0]    s_r, s_g, s_b;

    vga_frame_reader u_dut (
        .clk         (clk),
        .reset       (reset),
`ifdef VGA_TEST_PATTERN_EN
        .test_sel    (test_sel),
`endif
        .rd_en       (d_rd_en),
        .rd_addr     (d_rd_addr),
        .rd_data     (d_rd_data),
        .vga_r       (d_r),
        .vga_g       (d_g),
        .vga_b       (d_b),
        .vga_hsync   (d_hs),
        .vga_vsync   (d_vs),
        .frame_start (d_fs)
    );

    vga_frame_reader #(
        .H_ACTIVE (S_HA), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
        .V_ACTIVE (S_VA), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB),
        .ADDR_W   (AW),   .SYNC_POL (1'b1)
    ) u_small (
        .clk         (clk),
        .reset       (reset),
`ifdef VGA_TEST_PATTERN_EN
        .test_sel    (test_sel),
`endif
        .rd_en       (s_rd_en),
        .rd_addr     (s_rd_addr),
        .rd_data     (s_rd_data),
        .vga_r       (s_r),
        .vga_g       (s_g),
        .vga_b       (s_b),
        .vga_hsync   (s_hs),
        .vga_vsync   (s_vs),
        .frame_start (s_fs)
    );

    // Buffer models: one-cycle read latency, random junk when not read.
    always @(posedge clk) begin
        d_rd_data <= d_rd_en ? (d_rd_addr[11:0] ^ key) : 12'($urandom);
        s_rd_data <= s_rd_en ? (s_rd_addr[11:0] ^ key) : 12'($urandom);
    end

    // Edges since reset was released.
    always @(posedge clk) k <= reset ? 0 : k + 1;

    function automatic pins_t get_d();
        pins_t a;
        a.rd_en = d_rd_en; a.rd_addr = d_rd_addr; a.rgb = {d_r, d_g, d_b};
        a.hs = d_hs; a.vs = d_vs; a.fs = d_fs;
        return a;
    endfunction

    function automatic pins_t get_s();
        pins_t a;
        a.rd_en = s_rd_en; a.rd_addr = s_rd_addr; a.rgb = {s_r, s_g, s_b};
        a.hs = s_hs; a.vs = s_vs; a.fs = s_fs;
        return a;
    endfunction

    // Reference: after c edges, the read port reflects raster position c-1
    // and the pins reflect position c-3 (earlier => reset values).
    function automatic pins_t model(tim_t t, int c, logic tsel, logic [11:0] kk);
        int ht, ft, p, x, y, n;
        pins_t m;
        ht = t.ha + t.hf + t.hs + t.hb;
        ft = ht * (t.va + t.vf + t.vs + t.vb);
        m.rd_en = 1'b0; m.rd_addr = '0; m.rgb = '0;
        m.hs = !t.pol; m.vs = !t.pol; m.fs = 1'b0;
        if (c >= 1) begin
            p = (c - 1) % ft; x = p % ht; y = p / ht;
            n = (y < t.va) ? y * t.ha + ((x < t.ha) ? x : t.ha) : t.ha * t.va;
            if (tsel) begin
                m.rd_addr = '0;
            end else if (x < t.ha && y < t.va) begin
                m.rd_en = 1'b1; m.rd_addr = AW'(n);
            end else if (n > 0) begin
                m.rd_addr = AW'(n - 1);
            end else if (c - 1 >= ft) begin
                m.rd_addr = AW'(t.ha * t.va - 1);
            end
        end
        if (c >= 3) begin
            p = (c - 3) % ft; x = p % ht; y = p / ht;
            if (x < t.ha && y < t.va)
                m.rgb = tsel ? bars[x / 80] : (12'((y * t.ha + x) % 4096) ^ kk);
            m.hs = (x >= t.ha + t.hf && x < t.ha + t.hf + t.hs) ? t.pol : !t.pol;
            m.vs = (y >= t.va + t.vf && y < t.va + t.vf + t.vs) ? t.pol : !t.pol;
            m.fs = (p == 0);
        end
        return m;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        pins_t a, e;
        reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            a = get_d(); e = model(td, k, test_sel, key);
            n_tests++;
            if (a !== e) begin n_fail++; $display("FAIL reset_default got %h expected %h", a, e); end
            a = get_s(); e = model(ts, k, test_sel, key);
            n_tests++;
            if (a !== e) begin n_fail++; $display("FAIL reset_small got %h expected %h", a, e); end
        end
    endtask

    task automatic test_hsync();
        pins_t a, e;
        int on1 = -1, off1 = -1, on2 = -1;
        logic prev = 1'b1;
        do_reset();
        repeat (2500) begin
            @(negedge clk);
            a = get_d(); e = model(td, k, test_sel, key);
            n_tests++;
            if (a.hs !== e.hs || a.vs !== e.vs) begin
                n_fail++; $display("FAIL hsync k=%0d got hs=%b vs=%b expected hs=%b vs=%b", k, a.hs, a.vs, e.hs, e.vs);
            end
            if (prev && !a.hs) begin
                if (on1 < 0) on1 = k; else if (on2 < 0) on2 = k;
            end
            if (!prev && a.hs && off1 < 0) off1 = k;
            prev = a.hs;
        end
        n_tests++;
        if (on1 != 659) begin n_fail++; $display("FAIL hsync_first got %0d expected 659", on1); end
        n_tests++;
        if (off1 - on1 != 96) begin n_fail++; $display("FAIL hsync_width got %0d expected 96", off1 - on1); end
        n_tests++;
        if (on2 - on1 != 800) begin n_fail++; $display("FAIL hsync_period got %0d expected 800", on2 - on1); end
    endtask

    task automatic test_address();
        pins_t a, e;
        do_reset();
        repeat (1700) begin
            @(negedge clk);
            a = get_d(); e = model(td, k, test_sel, key);
            n_tests++;
            if (a.rd_en !== e.rd_en || a.rd_addr !== e.rd_addr) begin
                n_fail++; $display("FAIL address k=%0d got en=%b addr=%0d expected en=%b addr=%0d",
                                   k, a.rd_en, a.rd_addr, e.rd_en, e.rd_addr);
            end
            if (k == 801) begin
                n_tests++;
                if (a.rd_en !== 1'b1 || a.rd_addr !== AW'(640)) begin
                    n_fail++; $display("FAIL address_line1 got en=%b addr=%0d expected en=1 addr=640", a.rd_en, a.rd_addr);
                end
            end
        end
    endtask

    task automatic test_data();
        pins_t a, e;
        key = 12'($urandom);
        do_reset();
        repeat (2500) begin
            @(negedge clk);
            a = get_d(); e = model(td, k, test_sel, key);
            n_tests++;
            if (a.rgb !== e.rgb || a.fs !== e.fs) begin
                n_fail++; $display("FAIL data k=%0d got rgb=%h fs=%b expected rgb=%h fs=%b", k, a.rgb, a.fs, e.rgb, e.fs);
            end
            if (k == 3) begin
                n_tests++;
                if (a.fs !== 1'b1 || a.rgb !== key) begin
                    n_fail++; $display("FAIL data_first_pixel got fs=%b rgb=%h expected fs=1 rgb=%h", a.fs, a.rgb, key);
                end
            end
        end
    endtask

    task automatic test_frame_small();
        pins_t a, e;
        int run = 3 * S_FT + 10;
        int n_fs = 0, last_fs = -1, vs_w = 0, max_addr = 0;
        key = 12'($urandom);
        do_reset();
        repeat (run) begin
            @(negedge clk);
            a = get_s(); e = model(ts, k, test_sel, key);
            n_tests++;
            if (a !== e) begin n_fail++; $display("FAIL frame_small k=%0d got %h expected %h", k, a, e); end
            a = get_d(); e = model(td, k, test_sel, key);
            n_tests++;
            if (a !== e) begin n_fail++; $display("FAIL frame_default k=%0d got %h expected %h", k, a, e); end
            if (s_fs === 1'b1) begin
                n_fs++;
                if (last_fs >= 0) begin
                    n_tests++;
                    if (k - last_fs != S_FT) begin
                        n_fail++; $display("FAIL frame_period got %0d expected %0d", k - last_fs, S_FT);
                    end
                end
                last_fs = k;
            end
            if (s_vs === 1'b1 && k < S_FT) vs_w++;
            if (int'(s_rd_addr) > max_addr) max_addr = int'(s_rd_addr);
        end
        n_tests++;
        if (n_fs != (run - 3) / S_FT + 1) begin
            n_fail++; $display("FAIL frame_count got %0d expected %0d", n_fs, (run - 3) / S_FT + 1);
        end
        n_tests++;
        if (vs_w != S_VS * S_HT) begin n_fail++; $display("FAIL vsync_width got %0d expected %0d", vs_w, S_VS * S_HT); end
        n_tests++;
        if (max_addr != S_HA * S_VA - 1) begin
            n_fail++; $display("FAIL last_addr got %0d expected %0d", max_addr, S_HA * S_VA - 1);
        end
    endtask

    task automatic test_mid_reset();
        pins_t a, e;
        int r;
        key = 12'($urandom);
        do_reset();
        r = $urandom_range(680, 740);  // default DUT mid-hsync, small DUT mid-vsync
        repeat (r) begin
            @(negedge clk);
            a = get_d(); e = model(td, k, test_sel, key);
            n_tests++;
            if (a !== e) begin n_fail++; $display("FAIL pre_reset_default k=%0d got %h expected %h", k, a, e); end
        end
        reset = 1'b1;
        repeat (5) begin
            @(negedge clk);
            a = get_d(); e = model(td, k, test_sel, key);
            n_tests++;
            if (a !== e) begin n_fail++; $display("FAIL in_reset_default got %h expected %h", a, e); end
            a = get_s(); e = model(ts, k, test_sel, key);
            n_tests++;
            if (a !== e) begin n_fail++; $display("FAIL in_reset_small got %h expected %h", a, e); end
        end
        reset = 1'b0;
        repeat (1000) begin
            @(negedge clk);
            a = get_d(); e = model(td, k, test_sel, key);
            n_tests++;
            if (a !== e) begin n_fail++; $display("FAIL post_reset_default k=%0d got %h expected %h", k, a, e); end
            a = get_s(); e = model(ts, k, test_sel, key);
            n_tests++;
            if (a !== e) begin n_fail++; $display("FAIL post_reset_small k=%0d got %h expected %h", k, a, e); end
            if (k == 3) begin
                n_tests++;
                if (d_fs !== 1'b1 || s_fs !== 1'b1) begin
                    n_fail++; $display("FAIL restart_frame_start got %b/%b expected 1/1", d_fs, s_fs);
                end
            end
        end
    endtask

`ifdef VGA_TEST_PATTERN_EN
    task automatic test_pattern();
        pins_t a, e;
        test_sel = 1'b1;
        do_reset();
        repeat (1700) begin
            @(negedge clk);
            a = get_d(); e = model(td, k, test_sel, key);
            n_tests++;
            if (a !== e) begin n_fail++; $display("FAIL pattern_default k=%0d got %h expected %h", k, a, e); end
            a = get_s(); e = model(ts, k, test_sel, key);
            n_tests++;
            if (a !== e) begin n_fail++; $display("FAIL pattern_small k=%0d got %h expected %h", k, a, e); end
            if (k == 3 || k == 82 || k == 83 || k == 563) begin
                n_tests++;
                if ({d_r, d_g, d_b} !== ((k < 83) ? 12'hFFF : (k == 83) ? 12'hFF0 : 12'h000)) begin
                    n_fail++; $display("FAIL pattern_bar k=%0d got %h", k, {d_r, d_g, d_b});
                end
            end
        end
        test_sel = 1'b0;
    endtask
`endif

    initial begin
        td = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
        ts = '{S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 1'b1};
        test_reset();
        test_hsync();
        test_address();
        test_data();
        test_frame_small();
        test_mid_reset();
`ifdef VGA_TEST_PATTERN_EN
        test_pattern();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_frame_reader.md
# vga_frame_reader

Read-side engine for the 640x480x12-bit camera frame buffer. It generates 640x480@60 VGA timing from a 25 MHz pixel clock and issues one read per active pixel to the buffer's read port. It registers the returned pixel onto the 4:4:4 RGB pins, with hsync/vsync delayed to stay aligned. It sits between the frame buffer's read port and the board VGA connector.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width
- V_BP, 33, vertical back porch
- ADDR_W, 19, frame buffer address width
- SYNC_POL, 0, asserted sync level (0 = active-low)

Ports:
- clk  in  1  pixel clock, 25 MHz; same clock as the buffer's read clock
- reset  in  1  synchronous, active-high
- rd_en  out  1  buffer read enable
- rd_addr  out  ADDR_W  buffer read address
- rd_data  in  12  buffer read data, {R[11:8],G[7:4],B[3:0]}, valid one cycle after rd_en
- vga_r / vga_g / vga_b  out  4 each  pixel colour
- vga_hsync  out  1  horizontal sync
- vga_vsync  out  1  vertical sync
- frame_start  out  1  one-cycle pulse coincident with pixel (0,0) on the pins
- test_sel  in  1  colour-bar select; present only with VGA_TEST_PATTERN_EN

## Operation
- Counters:
  - h_cnt runs 0..H_TOTAL-1 (800) and wraps to 0.
  - v_cnt increments on the h_cnt wrap, runs 0..V_TOTAL-1 (525), then wraps.
  - Active region is h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
- Sync:
  - hsync is asserted (level SYNC_POL) for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751].
  - vsync is asserted for v_cnt in [490,491] over full lines.
- Address:
  - A pixel counter increments by 1 per active pixel and holds outside the active region.
  - It is cleared to 0 when (h_cnt,v_cnt) = (H_TOTAL-1,V_TOTAL-1).
  - It never wraps by overflow; the last value in a frame is 307199.
- Pipeline, 3 stages; stage 0 is the counters:
  - S1: registered rd_en = active and rd_addr = pixel counter. Sync and active flags are delayed 1 cycle.
  - S2: the buffer returns rd_data. Flags are delayed a 2nd cycle.
  - S3: RGB is registered from rd_data when the delayed active flag is 1, else 0 (blanking). hsync/vsync/frame_start are registered from the delayed flags.
- rd_addr holds its last value when rd_en = 0.
- Widths: h_cnt is 10 bits and v_cnt is 10 bits. Sync-window and H_TOTAL/V_TOTAL comparisons use parameter sums computed at elaboration.

## Timing
- Reset values:
  - h_cnt = v_cnt = 0; pixel counter 0.
  - rd_en 0, rd_addr 0, RGB 0, frame_start 0.
  - hsync/vsync deasserted (~SYNC_POL).
  - All pipeline flag registers are reset to the inactive state.
- The first clock after reset deasserts has the counters at (0,0).
  - rd_en=1 with rd_addr=0 on the following edge.
  - frame_start and pixel 0 appear on the pins 3 cycles after counters = (0,0).
- Latency from counter value to pins is exactly 3 cycles for RGB, both syncs and frame_start. Relative alignment between them is always exact.
- Reset asserted mid-frame:
  - All outputs return to reset values on the next edge; no partial sync pulse is continued.
  - The frame restarts at (0,0) after release.
- Line period 800 cycles; frame period 420000 cycles; hsync width 96 cycles; vsync width 1600 cycles.

## Configuration
- VGA_TEST_PATTERN_EN defined:
  - The test_sel port exists.
  - When test_sel=1, S3 drives 8 vertical colour bars 80 px wide in the order white, yellow, cyan, green, magenta, red, blue, black. The colour index is derived from the 2-cycle-delayed h_cnt[9:0]/80.
  - rd_en is forced to 0 while test_sel=1.
  - Sync timing is unchanged.
- Not defined: no test_sel port; RGB always comes from rd_data.

## Structure
- Shared package vga_pkg holds:
  - default 640x480@60 timing constants and H_TOTAL/V_TOTAL;
  - FB_DEPTH = 307200 and ADDR_W;
  - the 12-bit pixel packing ({R,G,B} nibble positions);
  - the colour-bar palette.
- One sub-module, vga_timing, holds the h/v counters and raw active/hsync/vsync/frame-start flags. vga_frame_reader holds address generation, the pipeline and the colour stage.

## Test plan
- Reset, then release: all outputs hold reset values during reset. First vga_hsync assertion occurs at cycle 659 after release (656+3), lasts 96 cycles and repeats every 800.
- Address sweep: rd_addr = 0..639 on cycles 1..640 with rd_en=1. rd_en=0 for the next 160 cycles. rd_addr=640 at cycle 801. Final read is 307199 and the next frame starts at 0; vsync width 1600, period 420000.
- Data alignment: buffer model returns rd_data = rd_addr[11:0] one cycle after rd_en. Pin pixel at h position x of line y equals (y*640+x) mod 4096. RGB = 0 in all blanking cycles.
- frame_start: exactly one pulse per 420000 cycles, coincident with RGB = 12'h000 from address 0. It falls in the same cycle as the first active pixel after vsync.
- Mid-frame reset at v_cnt=200, h_cnt=300 for 5 cycles: outputs return to reset values. No residual sync pulse occurs. Next frame_start arrives 3 cycles after release.
- With VGA_TEST_PATTERN_EN and test_sel=1: rd_en stays 0. Pixels 0..79 are 12'hFFF, 80..159 are 12'hFF0, and pixels 560..639 are 12'h000.
